hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage core (IF, ID, EX, MEM, WB). Sits beside the instruction decoder and register file.
- Tracks destination registers in flight in EX/MEM/WB and computes registered operand-forwarding selects for the EX stage.
- Detects load-use hazards and stalls IF/ID with an EX bubble; flushes younger instructions on taken branches/jumps.
- Freezes the whole pipe while data memory is busy; keeps performance counters for stalls and flushes.

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipe: tracks in-flight destinations,
// produces registered forwarding selects, load-use stalls, branch flushes and freeze.
module hazard_ctrl #(
    parameter int unsigned FLUSH_EXTRA = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_rf_wr_en_i,
    input  logic             id_is_load_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_busy_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             flush_id_o,
    output logic             bubble_ex_o,
    output logic             freeze_o,
    output logic [1:0]       fwd_rs1_sel_o,
    output logic [1:0]       fwd_rs2_sel_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [2:0] FX       = 3'(FLUSH_EXTRA);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
    } slot_t;

    slot_t            r_ex, r_mem, r_wb;
    logic [0:0]       r_state;
    logic [2:0]       r_fcnt;
    logic [1:0]       r_fwd1, r_fwd2;
    logic [CNT_W-1:0] r_lu_cnt, r_fl_cnt;

    function automatic logic hit(input slot_t s, input logic [4:0] rs, input logic used);
        return s.valid && s.wr_en && (s.rd == rs) && used && (rs != 5'd0);
    endfunction

    // Youngest producer wins: EX, then MEM, then WB (retire latch).
    function automatic logic [1:0] sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                       input logic [4:0] rs, input logic used);
        if (hit(ex, rs, used))       return 2'd1;
        else if (hit(mem, rs, used)) return 2'd2;
        else if (hit(wb, rs, used))  return 2'd3;
        else                         return 2'd0;
    endfunction

    logic  w_freeze, w_flush, w_lu, w_issue, w_branch;
    slot_t w_id_slot;

    assign w_freeze  = mem_busy_i;
    assign w_branch  = !w_freeze && ex_branch_taken_i;
    assign w_flush   = !w_freeze && (ex_branch_taken_i || (r_state == ST_FLUSH));
    assign w_lu      = !w_freeze && !w_flush && id_valid_i && r_ex.is_load &&
                       (hit(r_ex, id_rs1_i, id_rs1_used_i) || hit(r_ex, id_rs2_i, id_rs2_used_i));
    assign w_issue   = id_valid_i && !w_freeze && !w_flush && !w_lu;
    assign w_id_slot = '{valid: 1'b1, rd: id_rd_i, wr_en: id_rf_wr_en_i, is_load: id_is_load_i};

    assign freeze_o    = w_freeze;
    assign stall_if_o  = w_freeze || w_lu;
    assign stall_id_o  = w_freeze || w_lu;
    assign flush_id_o  = w_flush;
    assign bubble_ex_o = w_flush || w_lu;

    assign fwd_rs1_sel_o  = r_fwd1;
    assign fwd_rs2_sel_o  = r_fwd2;
    assign lu_stall_cnt_o = r_lu_cnt;
    assign flush_cnt_o    = r_fl_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex   <= '0;
            r_mem  <= '0;
            r_wb   <= '0;
            r_fwd1 <= '0;
            r_fwd2 <= '0;
        end else if (!w_freeze) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_issue) begin
                r_ex   <= w_id_slot;
                r_fwd1 <= sel(r_ex, r_mem, r_wb, id_rs1_i, id_rs1_used_i);
                r_fwd2 <= sel(r_ex, r_mem, r_wb, id_rs2_i, id_rs2_used_i);
            end else begin
                r_ex   <= '0;
                r_fwd1 <= '0;
                r_fwd2 <= '0;
            end
        end
    end

    // Flush lasts 1 + FLUSH_EXTRA unfrozen cycles; a repeat branch reloads the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else if (w_branch) begin
            if (FLUSH_EXTRA > 0) begin
                r_state <= ST_FLUSH;
                r_fcnt  <= FX;
            end else begin
                r_state <= ST_RUN;
                r_fcnt  <= '0;
            end
        end else if (!w_freeze && (r_state == ST_FLUSH)) begin
            r_fcnt <= r_fcnt - 3'd1;
            if (r_fcnt <= 3'd1) r_state <= ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lu_cnt <= '0;
            r_fl_cnt <= '0;
        end else begin
            if (w_lu && (r_lu_cnt != '1))     r_lu_cnt <= r_lu_cnt + 1'b1;
            if (w_branch && (r_fl_cnt != '1)) r_fl_cnt <= r_fl_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed per-feature cycle tables with a
// queue of expected forwarding selects checked one cycle after each drive.
module tb_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic          clk, rst;
    logic          id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rf_wr_en_i, id_is_load_i;
    logic [4:0]    id_rs1_i, id_rs2_i, id_rd_i;
    logic          ex_branch_taken_i, mem_busy_i;
    logic          stall_if_o, stall_id_o, flush_id_o, bubble_ex_o, freeze_o;
    logic [1:0]    fwd_rs1_sel_o, fwd_rs2_sel_o;
    logic [CW-1:0] lu_stall_cnt_o, flush_cnt_o;

    hazard_ctrl #(.FLUSH_EXTRA(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_i(id_rd_i), .id_rf_wr_en_i(id_rf_wr_en_i), .id_is_load_i(id_is_load_i),
        .ex_branch_taken_i(ex_branch_taken_i), .mem_busy_i(mem_busy_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .flush_id_o(flush_id_o),
        .bubble_ex_o(bubble_ex_o), .freeze_o(freeze_o),
        .fwd_rs1_sel_o(fwd_rs1_sel_o), .fwd_rs2_sel_o(fwd_rs2_sel_o),
        .lu_stall_cnt_o(lu_stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {stall_if, stall_id, flush_id, bubble_ex, freeze}; fwd = {rs1_sel, rs2_sel}
    typedef struct packed {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       we, ld, br, busy;
        logic [4:0] ctl;
        logic [3:0] fwd;
    } cyc_t;

    logic [4:0]    w_ctl;
    logic [3:0]    w_fwd;
    assign w_ctl = {stall_if_o, stall_id_o, flush_id_o, bubble_ex_o, freeze_o};
    assign w_fwd = {fwd_rs1_sel_o, fwd_rs2_sel_o};

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [3:0]    fq[$];
    logic [CW-1:0] exp_lu, exp_fl;

    localparam logic [4:0] C_OK = 5'b00000;
    localparam logic [4:0] C_LU = 5'b11010;
    localparam logic [4:0] C_FL = 5'b00110;
    localparam logic [4:0] C_FZ = 5'b11001;

    function automatic cyc_t mk(input logic v, input logic [4:0] rs1, rs2, input logic u1, u2,
                                input logic [4:0] rd, input logic we, ld, br, busy,
                                input logic [4:0] ctl, input logic [3:0] fwd);
        cyc_t c;
        c = '{v: v, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, we: we, ld: ld,
              br: br, busy: busy, ctl: ctl, fwd: fwd};
        return c;
    endfunction

    function automatic cyc_t nop(input logic br, busy, input logic [4:0] ctl, input logic [3:0] fwd);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, br, busy, ctl, fwd);
    endfunction

    task automatic apply(input cyc_t c);
        id_valid_i = c.v;  id_rs1_i = c.rs1; id_rs2_i = c.rs2;
        id_rs1_used_i = c.u1; id_rs2_used_i = c.u2;
        id_rd_i = c.rd; id_rf_wr_en_i = c.we; id_is_load_i = c.ld;
        ex_branch_taken_i = c.br; mem_busy_i = c.busy;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        apply(nop(1'b0, 1'b0, C_OK, 4'b0000));
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({w_ctl, w_fwd, lu_stall_cnt_o, flush_cnt_o} !== '0) begin
            n_bad++; $display("FAIL reset_state got %b/%b/%0d/%0d expected all zero", w_ctl, w_fwd, lu_stall_cnt_o, flush_cnt_o);
        end
        @(posedge clk); #1; rst = 1'b1;
        apply(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        @(posedge clk); #1;
        apply(mk(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, C_OK, 4'b0000));
        @(posedge clk); #1;
        apply(mk(1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        #2;
        n_cmp++;
        if (w_ctl !== C_LU) begin n_bad++; $display("FAIL pre_reset_ctl got %b expected %b", w_ctl, C_LU); end
        n_cmp++;
        if (w_fwd !== 4'b0100) begin n_bad++; $display("FAIL pre_reset_fwd got %b expected 0100", w_fwd); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({w_ctl, w_fwd, lu_stall_cnt_o, flush_cnt_o} !== '0) begin
            n_bad++; $display("FAIL async_reset got %b/%b/%0d/%0d expected all zero", w_ctl, w_fwd, lu_stall_cnt_o, flush_cnt_o);
        end
        apply(nop(1'b0, 1'b0, C_OK, 4'b0000));
        @(posedge clk); #1; rst = 1'b1;
        apply(mk(1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        @(negedge clk);
        n_cmp++;
        if (w_ctl !== C_OK) begin n_bad++; $display("FAIL post_reset_ctl got %b expected %b", w_ctl, C_OK); end
        fq.delete();
        fq.push_back(4'b0000);
        @(posedge clk); #1;
    endtask

    task automatic test_forward;
        cyc_t t[$];
        logic [3:0] e;
        t.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(mk(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0101));
        t.push_back(mk(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b1001));
        t.push_back(mk(1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1, C_FZ, 4'b1001));
        t.push_back(mk(1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0111));
        t.push_back(nop(1'b0, 1'b0, C_OK, 4'b0000));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            if (fq.size() > 0) begin
                e = fq.pop_front(); n_cmp++;
                if (w_fwd !== e) begin n_bad++; $display("FAIL forward_fwd[%0d] got %b expected %b", i, w_fwd, e); end
            end
            n_cmp++;
            if (w_ctl !== t[i].ctl) begin n_bad++; $display("FAIL forward_ctl[%0d] got %b expected %b", i, w_ctl, t[i].ctl); end
            fq.push_back(t[i].fwd);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use;
        cyc_t t[$];
        logic [3:0] e;
        t.push_back(mk(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(mk(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, C_LU, 4'b0000));
        t.push_back(mk(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b1000));
        t.push_back(mk(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(mk(1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(nop(1'b0, 1'b0, C_OK, 4'b0000));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            if (fq.size() > 0) begin
                e = fq.pop_front(); n_cmp++;
                if (w_fwd !== e) begin n_bad++; $display("FAIL loaduse_fwd[%0d] got %b expected %b", i, w_fwd, e); end
            end
            n_cmp++;
            if (w_ctl !== t[i].ctl) begin n_bad++; $display("FAIL loaduse_ctl[%0d] got %b expected %b", i, w_ctl, t[i].ctl); end
            fq.push_back(t[i].fwd);
            @(posedge clk); #1;
        end
        exp_lu = 4'd1;
        n_cmp++;
        if (lu_stall_cnt_o !== exp_lu) begin n_bad++; $display("FAIL loaduse_cnt got %0d expected %0d", lu_stall_cnt_o, exp_lu); end
    endtask

    task automatic test_wb_and_x0;
        cyc_t t[$];
        logic [3:0] e;
        t.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(mk(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(mk(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b1100));
        t.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(nop(1'b0, 1'b0, C_OK, 4'b0000));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            if (fq.size() > 0) begin
                e = fq.pop_front(); n_cmp++;
                if (w_fwd !== e) begin n_bad++; $display("FAIL wbx0_fwd[%0d] got %b expected %b", i, w_fwd, e); end
            end
            n_cmp++;
            if (w_ctl !== t[i].ctl) begin n_bad++; $display("FAIL wbx0_ctl[%0d] got %b expected %b", i, w_ctl, t[i].ctl); end
            fq.push_back(t[i].fwd);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush;
        cyc_t t[$];
        cyc_t a;
        logic [3:0] e;
        a = mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000);
        t.push_back(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, C_FZ, 4'b0000));
        t.push_back(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, C_FL, 4'b0000));
        t.push_back(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, C_FL, 4'b0000));
        t.push_back(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, C_FL, 4'b0000));
        t.push_back(a);
        t.push_back(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, C_FL, 4'b0000));
        for (int k = 0; k < 4; k++)
            t.push_back(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, C_FZ, 4'b0000));
        t.push_back(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, C_FL, 4'b0000));
        t.push_back(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, C_FL, 4'b0000));
        t.push_back(a);
        t.push_back(nop(1'b0, 1'b0, C_OK, 4'b0000));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            if (fq.size() > 0) begin
                e = fq.pop_front(); n_cmp++;
                if (w_fwd !== e) begin n_bad++; $display("FAIL flush_fwd[%0d] got %b expected %b", i, w_fwd, e); end
            end
            n_cmp++;
            if (w_ctl !== t[i].ctl) begin n_bad++; $display("FAIL flush_ctl[%0d] got %b expected %b", i, w_ctl, t[i].ctl); end
            fq.push_back(t[i].fwd);
            @(posedge clk); #1;
        end
        exp_fl = 4'd2;
        n_cmp++;
        if (flush_cnt_o !== exp_fl) begin n_bad++; $display("FAIL flush_cnt got %0d expected %0d", flush_cnt_o, exp_fl); end
    endtask

    task automatic test_flush_vs_lu;
        cyc_t t[$];
        logic [3:0] e;
        t.push_back(mk(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, C_OK, 4'b0000));
        t.push_back(mk(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, C_FL, 4'b0000));
        t.push_back(mk(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C_FL, 4'b0000));
        t.push_back(mk(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C_FL, 4'b0000));
        t.push_back(nop(1'b0, 1'b0, C_OK, 4'b0000));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            if (fq.size() > 0) begin
                e = fq.pop_front(); n_cmp++;
                if (w_fwd !== e) begin n_bad++; $display("FAIL flushlu_fwd[%0d] got %b expected %b", i, w_fwd, e); end
            end
            n_cmp++;
            if (w_ctl !== t[i].ctl) begin n_bad++; $display("FAIL flushlu_ctl[%0d] got %b expected %b", i, w_ctl, t[i].ctl); end
            fq.push_back(t[i].fwd);
            @(posedge clk); #1;
        end
        exp_fl = exp_fl + 4'd1;
        n_cmp++;
        if ({lu_stall_cnt_o, flush_cnt_o} !== {exp_lu, exp_fl}) begin
            n_bad++; $display("FAIL flushlu_cnts got lu=%0d fl=%0d expected lu=%0d fl=%0d", lu_stall_cnt_o, flush_cnt_o, exp_lu, exp_fl);
        end
    endtask

    task automatic test_saturation;
        fq.delete();
        for (int k = 0; k < 16; k++) begin
            apply(mk(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, C_OK, 4'b0000));
            @(posedge clk); #1;
            apply(mk(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C_OK, 4'b0000));
            @(negedge clk);
            n_cmp++;
            if (w_ctl !== C_LU) begin n_bad++; $display("FAIL sat_lu_ctl[%0d] got %b expected %b", k, w_ctl, C_LU); end
            if (exp_lu != '1) exp_lu = exp_lu + 4'd1;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (lu_stall_cnt_o !== exp_lu) begin n_bad++; $display("FAIL sat_lu_cnt got %0d expected %0d", lu_stall_cnt_o, exp_lu); end
        for (int k = 0; k < 14; k++) begin
            apply(nop(1'b1, 1'b0, C_FL, 4'b0000));
            @(negedge clk);
            n_cmp++;
            if (w_ctl !== C_FL) begin n_bad++; $display("FAIL sat_fl_ctl[%0d] got %b expected %b", k, w_ctl, C_FL); end
            if (exp_fl != '1) exp_fl = exp_fl + 4'd1;
            @(posedge clk); #1;
            apply(nop(1'b0, 1'b0, C_FL, 4'b0000));
            repeat (2) @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++;
        if (w_ctl !== C_OK) begin n_bad++; $display("FAIL sat_idle_ctl got %b expected %b", w_ctl, C_OK); end
        n_cmp++;
        if (flush_cnt_o !== exp_fl) begin n_bad++; $display("FAIL sat_fl_cnt got %0d expected %0d", flush_cnt_o, exp_fl); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        exp_lu = '0;
        exp_fl = '0;
        test_reset();
        test_forward();
        test_load_use();
        test_wb_and_x0();
        test_flush();
        test_flush_vs_lu();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
